// File: rtl/bp_eth_io_cmd_arbiter.sv
// Shares one uncached I/O command/response channel between the Ethernet RX writer (id 0) and TX reader (id 1).
// Build option ETH_ARB_RX_PRIORITY_EN: fixed RX priority in IDLE instead of round-robin.
module bp_eth_io_cmd_arbiter
  #(parameter int unsigned bp_params_p          = 0  // 0 selects e_bp_default_cfg
   ,parameter int unsigned cce_mem_msg_width_lp = (bp_params_p == 0) ? 128 : 512
   ,parameter int unsigned max_outstanding_p    = 16
  )
  (input  logic                                 clk_i
  ,input  logic                                 reset_n_i
  ,input  logic [cce_mem_msg_width_lp-1:0]      rx_io_cmd_i
  ,input  logic                                 rx_io_cmd_v_i
  ,input  logic                                 rx_io_cmd_lock_i
  ,output logic                                 rx_io_cmd_yumi_o
  ,input  logic [cce_mem_msg_width_lp-1:0]      tx_io_cmd_i
  ,input  logic                                 tx_io_cmd_v_i
  ,input  logic                                 tx_io_cmd_lock_i
  ,output logic                                 tx_io_cmd_yumi_o
  ,output logic [cce_mem_msg_width_lp-1:0]      rx_io_resp_o
  ,output logic                                 rx_io_resp_v_o
  ,input  logic                                 rx_io_resp_ready_i
  ,output logic [cce_mem_msg_width_lp-1:0]      tx_io_resp_o
  ,output logic                                 tx_io_resp_v_o
  ,input  logic                                 tx_io_resp_ready_i
  ,output logic [cce_mem_msg_width_lp-1:0]      io_cmd_o
  ,output logic                                 io_cmd_v_o
  ,input  logic                                 io_cmd_yumi_i
  ,input  logic [cce_mem_msg_width_lp-1:0]      io_resp_i
  ,input  logic                                 io_resp_v_i
  ,output logic                                 io_resp_ready_o
  ,output logic [$clog2(max_outstanding_p):0]   outstanding_o
  ,output logic                                 orphan_resp_o
  );

  localparam int unsigned ptr_w = $clog2(max_outstanding_p);
  localparam int unsigned cnt_w = ptr_w + 1;
`ifdef ETH_ARB_RX_PRIORITY_EN
  localparam bit rx_prio = 1'b1;
`else
  localparam bit rx_prio = 1'b0;
`endif

  typedef enum logic [1:0] {e_idle, e_lock_rx, e_lock_tx} state_e;

  state_e               state_q, state_n;
  logic                 rr_q, rr_n;        // 0: RX wins a tie, 1: TX wins
  logic                 hold_v_q, hold_v_n;
  logic                 hold_id_q;
  logic                 gnt, gnt_v, gnt_lock, cmd_v, accept;
  logic [max_outstanding_p-1:0] order_q;
  logic [ptr_w-1:0]     wptr_q, rptr_q;
  logic [cnt_w-1:0]     count_q;
  logic                 fifo_full, fifo_empty, head, retire, orphan_q;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == cnt_w'(max_outstanding_p));

  // Grant selection and lock FSM; a presented-but-unaccepted grant is held stable.
  always_comb begin
    state_n  = state_q;
    rr_n     = rr_q;
    gnt      = 1'b0;
    unique case (state_q)
      e_lock_rx: gnt = 1'b0;
      e_lock_tx: gnt = 1'b1;
      default: begin
        if (hold_v_q)                          gnt = hold_id_q;
        else if (rx_io_cmd_v_i & tx_io_cmd_v_i) gnt = rx_prio ? 1'b0 : rr_q;
        else                                   gnt = tx_io_cmd_v_i;
      end
    endcase
    gnt_v    = gnt ? tx_io_cmd_v_i    : rx_io_cmd_v_i;
    gnt_lock = gnt ? tx_io_cmd_lock_i : rx_io_cmd_lock_i;
    cmd_v    = reset_n_i & gnt_v & ~fifo_full;
    accept   = cmd_v & io_cmd_yumi_i;
    hold_v_n = cmd_v & ~io_cmd_yumi_i;
    if (accept) begin
      unique case (state_q)
        e_lock_rx, e_lock_tx: if (!gnt_lock) state_n = e_idle;
        default: begin
          rr_n = ~gnt;
          if (gnt_lock) state_n = gnt ? e_lock_tx : e_lock_rx;
        end
      endcase
    end
  end

  assign io_cmd_v_o       = cmd_v;
  assign io_cmd_o         = gnt ? tx_io_cmd_i : rx_io_cmd_i;
  assign rx_io_cmd_yumi_o = accept & ~gnt;
  assign tx_io_cmd_yumi_o = accept & gnt;

  // Response routing by the oldest outstanding requester id.
  assign head            = order_q[rptr_q];
  assign io_resp_ready_o = reset_n_i & (fifo_empty | (head ? tx_io_resp_ready_i : rx_io_resp_ready_i));
  assign rx_io_resp_v_o  = reset_n_i & io_resp_v_i & ~fifo_empty & ~head;
  assign tx_io_resp_v_o  = reset_n_i & io_resp_v_i & ~fifo_empty & head;
  assign rx_io_resp_o    = io_resp_i;
  assign tx_io_resp_o    = io_resp_i;
  assign retire          = io_resp_v_i & io_resp_ready_o & ~fifo_empty;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= e_idle;
      rr_q      <= 1'b0;
      hold_v_q  <= 1'b0;
      hold_id_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      orphan_q  <= 1'b0;
    end else begin
      state_q   <= state_n;
      rr_q      <= rr_n;
      hold_v_q  <= hold_v_n;
      hold_id_q <= gnt;
      if (accept) wptr_q <= wptr_q + ptr_w'(1);
      if (retire) rptr_q <= rptr_q + ptr_w'(1);
      if (accept & ~retire)      count_q <= count_q + cnt_w'(1);
      else if (retire & ~accept) count_q <= count_q - cnt_w'(1);
      if (io_resp_v_i & fifo_empty) orphan_q <= 1'b1;
    end
  end

  // Order storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk_i) begin
    if (accept) order_q[wptr_q] <= gnt;
  end

  assign outstanding_o = count_q;
  assign orphan_resp_o = orphan_q;

endmodule

// File: tb/tb_bp_eth_io_cmd_arbiter.sv
// Randomized bench for bp_eth_io_cmd_arbiter against a queue-based reference model.
module tb_bp_eth_io_cmd_arbiter;
  localparam int unsigned W = 32;
  localparam int unsigned D = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n_i;
  logic [W-1:0] rx_io_cmd_i, tx_io_cmd_i, rx_io_resp_o, tx_io_resp_o, io_cmd_o, io_resp_i;
  logic rx_io_cmd_v_i, rx_io_cmd_lock_i, rx_io_cmd_yumi_o;
  logic tx_io_cmd_v_i, tx_io_cmd_lock_i, tx_io_cmd_yumi_o;
  logic rx_io_resp_v_o, rx_io_resp_ready_i, tx_io_resp_v_o, tx_io_resp_ready_i;
  logic io_cmd_v_o, io_cmd_yumi_i, io_resp_v_i, io_resp_ready_o, orphan_resp_o;
  logic [$clog2(D):0] outstanding_o;

  bp_eth_io_cmd_arbiter #(.cce_mem_msg_width_lp(W), .max_outstanding_p(D)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .rx_io_cmd_i(rx_io_cmd_i), .rx_io_cmd_v_i(rx_io_cmd_v_i), .rx_io_cmd_lock_i(rx_io_cmd_lock_i),
    .rx_io_cmd_yumi_o(rx_io_cmd_yumi_o),
    .tx_io_cmd_i(tx_io_cmd_i), .tx_io_cmd_v_i(tx_io_cmd_v_i), .tx_io_cmd_lock_i(tx_io_cmd_lock_i),
    .tx_io_cmd_yumi_o(tx_io_cmd_yumi_o),
    .rx_io_resp_o(rx_io_resp_o), .rx_io_resp_v_o(rx_io_resp_v_o), .rx_io_resp_ready_i(rx_io_resp_ready_i),
    .tx_io_resp_o(tx_io_resp_o), .tx_io_resp_v_o(tx_io_resp_v_o), .tx_io_resp_ready_i(tx_io_resp_ready_i),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_yumi_i(io_cmd_yumi_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_ready_o(io_resp_ready_o),
    .outstanding_o(outstanding_o), .orphan_resp_o(orphan_resp_o));

  typedef struct packed { logic lock; logic [W-1:0] data; } msg_t;
  typedef struct packed { logic id; logic [W-1:0] data; } fl_t;

  msg_t cur [2];
  bit   act [2];
  fl_t  inflight [$];
  int   owner, pref, prev;
  bit   resp_hold, exp_orphan;
  int   p_req, p_lock, p_yumi, p_resp, p_rdy;
  bit   resp_en;
  int   chk_cnt = 0;
  int   fail_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rnd(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // Expected grant: lock owner, else a still-pending offer, else tie-break rule, else the lone requester.
  function automatic int grant_model();
    if (owner >= 0) return owner;
    if (prev >= 0)  return prev;
    if (act[0] && act[1]) begin
`ifdef ETH_ARB_RX_PRIORITY_EN
      return 0;
`else
      return pref;
`endif
    end
    return act[1] ? 1 : 0;
  endfunction

  function automatic logic [W-1:0] resp_of(input logic [W-1:0] d);
    return d ^ W'(32'hA5A5_A5A5);
  endfunction

  task automatic model_reset();
    inflight.delete();
    owner = -1; pref = 0; prev = -1;
    resp_hold = 1'b0; exp_orphan = 1'b0;
  endtask

  // One clock: drive at posedge+1, check at negedge, advance the model, wait for the next edge.
  task automatic step();
    int g;
    bit ev, erdy, ret;
    logic dest;
    for (int r = 0; r < 2; r++) begin
      if (!act[r] && rnd(p_req)) begin
        act[r] = 1'b1;
        cur[r].data = W'($urandom);
        cur[r].lock = rnd(p_lock);
      end
    end
    g  = grant_model();
    ev = act[g] && (inflight.size() < D);
    rx_io_cmd_v_i = act[0]; rx_io_cmd_i = cur[0].data; rx_io_cmd_lock_i = cur[0].lock;
    tx_io_cmd_v_i = act[1]; tx_io_cmd_i = cur[1].data; tx_io_cmd_lock_i = cur[1].lock;
    io_cmd_yumi_i = ev && rnd(p_yumi);
    if (!resp_hold) io_resp_v_i = resp_en && (inflight.size() > 0) && rnd(p_resp);
    if (io_resp_v_i) io_resp_i = resp_of(inflight[0].data);
    rx_io_resp_ready_i = rnd(p_rdy);
    tx_io_resp_ready_i = rnd(p_rdy);
    #4;
    check_val("cmd_v", io_cmd_v_o, ev);
    if (ev) check_val("cmd_data", io_cmd_o, cur[g].data);
    check_val("rx_yumi", rx_io_cmd_yumi_o, io_cmd_yumi_i && g == 0);
    check_val("tx_yumi", tx_io_cmd_yumi_o, io_cmd_yumi_i && g == 1);
    dest = (inflight.size() > 0) ? inflight[0].id : 1'b0;
    erdy = (inflight.size() == 0) ? 1'b1 : (dest ? tx_io_resp_ready_i : rx_io_resp_ready_i);
    check_val("resp_ready", io_resp_ready_o, erdy);
    check_val("rx_resp_v", rx_io_resp_v_o, io_resp_v_i && dest == 1'b0);
    check_val("tx_resp_v", tx_io_resp_v_o, io_resp_v_i && dest == 1'b1);
    if (io_resp_v_i && !dest) check_val("rx_resp", rx_io_resp_o, resp_of(inflight[0].data));
    if (io_resp_v_i && dest)  check_val("tx_resp", tx_io_resp_o, resp_of(inflight[0].data));
    check_val("outstanding", outstanding_o, inflight.size());
    check_val("orphan", orphan_resp_o, exp_orphan);
    ret = io_resp_v_i && erdy;
    if (ret) begin
      void'(inflight.pop_front());
      resp_hold = 1'b0;
    end else begin
      resp_hold = io_resp_v_i;
    end
    if (io_cmd_yumi_i) begin
      inflight.push_back('{id: 1'(g), data: cur[g].data});
      act[g] = 1'b0;
      if (owner < 0) begin
        pref = 1 - g;
        if (cur[g].lock) owner = g;
      end else if (!cur[g].lock) begin
        owner = -1;
      end
      prev = -1;
    end else begin
      prev = (ev && owner < 0) ? g : -1;
    end
    @(posedge clk); #1;
  endtask

  // Two reset cycles with active inputs; everything visible must stay quiet.
  task automatic do_reset();
    reset_n_i = 1'b0;
    rx_io_cmd_v_i = 1'b1; tx_io_cmd_v_i = 1'b1;
    io_cmd_yumi_i = 1'b1; io_resp_v_i = 1'b1;
    rx_io_resp_ready_i = 1'b1; tx_io_resp_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_val("rst_cmd_v", io_cmd_v_o, 1'b0);
      check_val("rst_yumi", {rx_io_cmd_yumi_o, tx_io_cmd_yumi_o}, 2'b00);
      check_val("rst_resp_v", {rx_io_resp_v_o, tx_io_resp_v_o}, 2'b00);
      check_val("rst_ready", io_resp_ready_o, 1'b0);
      check_val("rst_outstanding", outstanding_o, 0);
      check_val("rst_orphan", orphan_resp_o, 1'b0);
    end
    io_cmd_yumi_i = 1'b0; io_resp_v_i = 1'b0;
    reset_n_i = 1'b1;
    model_reset();
  endtask

  // A response with nothing outstanding is swallowed and flagged.
  task automatic orphan_probe();
    rx_io_cmd_v_i = 1'b0; tx_io_cmd_v_i = 1'b0; io_cmd_yumi_i = 1'b0;
    io_resp_v_i = 1'b1; io_resp_i = W'($urandom);
    #4;
    check_val("orphan_ready", io_resp_ready_o, 1'b1);
    check_val("orphan_no_resp_v", {rx_io_resp_v_o, tx_io_resp_v_o}, 2'b00);
    @(posedge clk); #1;
    io_resp_v_i = 1'b0;
    prev = -1;
    exp_orphan = 1'b1;
  endtask

  task automatic set_phase(input int rq, input int lk, input int yu, input int rs, input int rd, input bit en);
    p_req = rq; p_lock = lk; p_yumi = yu; p_resp = rs; p_rdy = rd; resp_en = en;
  endtask

  initial begin
    reset_n_i = 1'b0;
    {rx_io_cmd_v_i, rx_io_cmd_lock_i, tx_io_cmd_v_i, tx_io_cmd_lock_i} = '0;
    {io_cmd_yumi_i, io_resp_v_i, rx_io_resp_ready_i, tx_io_resp_ready_i} = '0;
    rx_io_cmd_i = '0; tx_io_cmd_i = '0; io_resp_i = '0;
    act[0] = 1'b0; act[1] = 1'b0;
    cur[0] = '0; cur[1] = '0;
    model_reset();
    set_phase(0, 0, 0, 0, 100, 1'b0);
    @(posedge clk); #1;
    do_reset();
    orphan_probe();
    repeat (4) step();
    do_reset();
    // both requesters always valid, no locks, everything accepted at once
    set_phase(100, 0, 100, 100, 100, 1'b1);
    repeat (40) step();
    // frame locks mixed with random back-pressure
    set_phase(70, 45, 70, 60, 70, 1'b1);
    repeat (500) step();
    // fill the order FIFO with responses withheld, then drain
    set_phase(100, 10, 100, 0, 100, 1'b0);
    repeat (30) step();
    check_val("fill_count", outstanding_o, D);
    check_val("fill_blocks", io_cmd_v_o, 1'b0);
    set_phase(100, 10, 100, 100, 100, 1'b1);
    repeat (100) step();
    // heavy back-pressure on responses
    set_phase(60, 30, 50, 60, 30, 1'b1);
    repeat (1000) step();
    // reset with commands in flight; a late response becomes an orphan
    do_reset();
    orphan_probe();
    set_phase(80, 20, 80, 80, 80, 1'b1);
    repeat (50) step();
    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end
endmodule
